// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, the hardwired
// zero register number and the instruction word that flush/bubble consumers
// load in place of a squashed instruction.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MDU   = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  // $zero never carries a dependency, so a load targeting it can't stall.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // sll $0,$0,0 -- what IF/ID, ID/EX and EX/MEM hold after a flush or bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline. Resolves
// taken-branch squashes, multi-cycle mult/div occupancy of EX and load-use
// dependencies (in that priority order) and counts stall cycles.
// All control outputs are Mealy: combinational from state, count and inputs.
module hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mdu,
  input  logic             pcsrc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             ex_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  // Remaining hold cycles after the entry cycle; wide enough for MDU_LATENCY-2.
  localparam int MCW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;

  hz_state_t      state_q, state_d;
  logic [MCW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic           load_use;

  // Load in EX writing a register the instruction in ID is about to read.
  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State and mult/div countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Next-state and control decode; squash overrides everything, and reset
  // forces every control low.
  always_comb begin
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    ex_hold      = 1'b0;
    if (reset) begin
      state_d     = ST_RUN;
      mdu_cnt_d   = '0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (pcsrc) begin
      // Anything younger than the branch is squashed, including a mult/div.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_FLUSH;
      mdu_cnt_d    = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_mdu) begin
            // ID/EX is held, so a coincident load-use needs no bubble.
            ex_hold     = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = ST_MDU;
            mdu_cnt_d   = MCW'(MDU_LATENCY - 2);
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MDU: begin
          if (mdu_cnt_q != '0) begin
            ex_hold     = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            mdu_cnt_d   = mdu_cnt_q - MCW'(1);
          end else begin
            // Release cycle: the op leaves EX at the end of this cycle.
            state_d = ST_RUN;
            if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // ID/EX holds a bubble, so its load/mdu flags are meaningless.
          state_d = ST_RUN;
        end
        default: begin
          state_d   = ST_RUN;
          mdu_cnt_d = '0;
        end
      endcase
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (!pc_write && !reset),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share the stimulus:
// default parameters, MDU_LATENCY=2, and CNT_W=2 for saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_mdu, pcsrc;

  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, ex_hold;
  logic [1:0] state;
  logic [7:0] stall_cnt;

  logic       l2_pc_write, l2_if_id_write, l2_if_id_flush, l2_id_ex_bubble, l2_ex_mem_flush, l2_ex_hold;
  logic [1:0] l2_state;
  logic [7:0] l2_stall_cnt;

  logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ex_mem_flush, s_ex_hold;
  logic [1:0] s_state;
  logic [1:0] s_stall_cnt;

  int total = 0;
  int bad   = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_mdu(ex_mdu), .pcsrc(pcsrc),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .ex_hold(ex_hold),
    .state(state), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MDU_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_mdu(ex_mdu), .pcsrc(pcsrc),
    .pc_write(l2_pc_write), .if_id_write(l2_if_id_write), .if_id_flush(l2_if_id_flush),
    .id_ex_bubble(l2_id_ex_bubble), .ex_mem_flush(l2_ex_mem_flush), .ex_hold(l2_ex_hold),
    .state(l2_state), .stall_cnt(l2_stall_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_mdu(ex_mdu), .pcsrc(pcsrc),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_mem_flush(s_ex_mem_flush), .ex_hold(s_ex_hold),
    .state(s_state), .stall_cnt(s_stall_cnt)
  );

  // Scoreboard check: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_memread = 1'b0; ex_mdu = 1'b0; pcsrc = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic drive_load_use(input logic [4:0] rt_dst, input logic [4:0] rs,
                                input logic [4:0] rt, input logic uses_rt);
    ex_memread = 1'b1; ex_rt = rt_dst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    pcsrc = 1'b1;

    // Reset held three cycles with pcsrc asserted: everything forced low.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      check("rst_pc_write", pc_write, 0);
      check("rst_if_id_flush", if_id_flush, 0);
      check("rst_ex_mem_flush", ex_mem_flush, 0);
    end
    check("rst_if_id_write", if_id_write, 0);
    check("rst_bubble", id_ex_bubble, 0);
    check("rst_ex_hold", ex_hold, 0);
    check("rst_state", state, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    reset = 1'b0;
    idle();
    settle();
    check("idle_pc_write", pc_write, 1);
    check("idle_if_id_write", if_id_write, 1);

    // Load-use on rs: one stall cycle with a bubble.
    next_cycle();
    drive_load_use(5'd8, 5'd8, 5'd0, 1'b0);
    settle();
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    next_cycle();
    idle();
    settle();
    check("lu_cnt", stall_cnt, 1);
    check("lu_after_pc_write", pc_write, 1);

    // Load to $zero never stalls.
    drive_load_use(5'd0, 5'd0, 5'd0, 1'b1);
    settle();
    check("lu_r0_pc_write", pc_write, 1);
    check("lu_r0_bubble", id_ex_bubble, 0);

    // rt match without rt use: no stall; with rt use: stall.
    next_cycle();
    drive_load_use(5'd8, 5'd3, 5'd8, 1'b0);
    settle();
    check("lu_rt_unused_pc_write", pc_write, 1);
    id_uses_rt = 1'b1;
    settle();
    check("lu_rt_used_pc_write", pc_write, 0);
    next_cycle();
    idle();
    settle();
    check("lu_rt_cnt", stall_cnt, 2);

    // Mult/div held in ID/EX for four cycles, default latency 4.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      ex_mdu = 1'b1;
      settle();
      check($sformatf("mdu_hold_%0d", i), ex_hold, (i < 3) ? 1 : 0);
      check($sformatf("mdu_pc_write_%0d", i), pc_write, (i < 3) ? 0 : 1);
      check($sformatf("mdu_state_%0d", i), state, (i == 0) ? 0 : 1);
      // Latency 2: hold, release, then the still-asserted flag starts a new op.
      check($sformatf("lat2_hold_%0d", i), l2_ex_hold, (i % 2 == 0) ? 1 : 0);
      next_cycle();
    end
    idle();
    settle();
    check("mdu_state_end", state, 0);
    check("mdu_cnt", stall_cnt, 3);
    check("lat2_cnt", l2_stall_cnt, 2);
    check("mdu_hold_end", ex_hold, 0);

    // Squash in the second hold cycle of a mult/div.
    pulse_reset();
    ex_mdu = 1'b1;
    settle();
    check("sq_mdu_hold0", ex_hold, 1);
    next_cycle();
    pcsrc = 1'b1;
    settle();
    check("sq_hold_drop", ex_hold, 0);
    check("sq_if_id_flush", if_id_flush, 1);
    check("sq_bubble", id_ex_bubble, 1);
    check("sq_ex_mem_flush", ex_mem_flush, 1);
    check("sq_pc_write", pc_write, 1);
    next_cycle();
    idle();
    settle();
    check("sq_state_flush", state, 2);
    check("sq_flush_hold", ex_hold, 0);
    check("sq_flush_if_id_flush", if_id_flush, 0);
    next_cycle();
    settle();
    check("sq_state_run", state, 0);
    check("sq_no_hold", ex_hold, 0);
    check("sq_cnt", stall_cnt, 1);

    // Squash coincident with load-use, then a load seen during FLUSH.
    next_cycle();
    drive_load_use(5'd8, 5'd8, 5'd0, 1'b0);
    pcsrc = 1'b1;
    settle();
    check("sqlu_pc_write", pc_write, 1);
    check("sqlu_if_id_flush", if_id_flush, 1);
    next_cycle();
    pcsrc = 1'b0;
    settle();
    check("sqlu_state", state, 2);
    check("flush_lu_pc_write", pc_write, 1);
    check("flush_lu_bubble", id_ex_bubble, 0);
    next_cycle();
    idle();
    settle();
    check("sqlu_cnt", stall_cnt, 1);

    // Saturation on the 2-bit counter: five stalls in a row.
    pulse_reset();
    drive_load_use(5'd9, 5'd9, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) next_cycle();
    idle();
    settle();
    check("sat_cnt", s_stall_cnt, 3);
    check("sat_wide_cnt", stall_cnt, 5);

    // Async reset in mid-cycle clears the counter before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_cnt", stall_cnt, 0);
    check("async_sat_cnt", s_stall_cnt, 0);
    check("async_pc_write", pc_write, 0);
    next_cycle();
    reset = 1'b0;

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
